// File: rtl/transmissor_palavras_if.sv
// Register-load handshake between the word sequencer and its consumer.
// master = sequencer (drives Dado/Hab/status), slave = consumer/host side.
interface transmissor_palavras_if #(
   parameter int N = 4
);
   logic             Inicio;
   logic [4*N-1:0]   Palavras;
   logic             Fim;
   logic [3:0]       Dado;
   logic             Hab;
   logic             Ocupado;
   logic             Concluido;
   logic             Erro;
   logic [3:0]       Indice;

   modport master (
      input  Inicio, Palavras, Fim,
      output Dado, Hab, Ocupado, Concluido, Erro, Indice
   );

   modport slave (
      output Inicio, Palavras, Fim,
      input  Dado, Hab, Ocupado, Concluido, Erro, Indice
   );
endinterface

// File: rtl/transmissor_palavras.sv
// Sends a latched block of N 4-bit words over the Hab/Fim handshake,
// with a per-word timeout that aborts the block and raises a sticky Erro.
module transmissor_palavras #(
   parameter int N       = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   transmissor_palavras_if.master bus
);
   localparam int         IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [7:0] TC   = 8'(TIMEOUT);

   typedef enum logic [1:0] {OCIOSO, ENVIA, LIBERA} estado_t;

   estado_t             r_estado;
   logic [N-1:0][3:0]   r_buf;
   logic [IW-1:0]       r_idx;
   logic [7:0]          r_cnt;
   logic                r_primeiro;
   logic [3:0]          r_dado;
   logic                r_hab;
   logic                r_ocupado;
   logic                r_concl;
   logic                r_erro;

   logic [7:0]          w_cnt_inc;
   logic                w_tc;
   logic [IW-1:0]       w_prox;

   assign w_cnt_inc = r_cnt + 8'd1;
   assign w_tc      = (w_cnt_inc >= TC);
   assign w_prox    = r_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado   <= OCIOSO;
         r_buf      <= '0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_primeiro <= 1'b0;
         r_dado     <= '0;
         r_hab      <= 1'b0;
         r_ocupado  <= 1'b0;
         r_concl    <= 1'b0;
         r_erro     <= 1'b0;
      end else begin
         r_concl <= 1'b0;
         case (r_estado)
            OCIOSO: begin
               if (bus.Inicio) begin
                  r_buf      <= bus.Palavras;
                  r_idx      <= '0;
                  r_dado     <= bus.Palavras[3:0];
                  r_erro     <= 1'b0;
                  r_cnt      <= '0;
                  r_hab      <= 1'b1;
                  r_ocupado  <= 1'b1;
                  r_primeiro <= 1'b1;
                  r_estado   <= ENVIA;
               end
            end
            ENVIA: begin
               r_primeiro <= 1'b0;
               // A Fim left over from the previous word must not acknowledge this one.
               if (bus.Fim && !r_primeiro) begin
                  r_hab    <= 1'b0;
                  r_cnt    <= '0;
                  r_estado <= LIBERA;
               end else if (w_tc) begin
                  r_cnt     <= TC;
                  r_hab     <= 1'b0;
                  r_ocupado <= 1'b0;
                  r_erro    <= 1'b1;
                  r_estado  <= OCIOSO;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            LIBERA: begin
               if (!bus.Fim) begin
                  if (r_idx == LAST) begin
                     r_concl   <= 1'b1;
                     r_ocupado <= 1'b0;
                     r_estado  <= OCIOSO;
                  end else begin
                     r_idx      <= w_prox;
                     r_dado     <= r_buf[w_prox];
                     r_hab      <= 1'b1;
                     r_cnt      <= '0;
                     r_primeiro <= 1'b1;
                     r_estado   <= ENVIA;
                  end
               end else if (w_tc) begin
                  r_cnt     <= TC;
                  r_ocupado <= 1'b0;
                  r_erro    <= 1'b1;
                  r_estado  <= OCIOSO;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            default: r_estado <= OCIOSO;
         endcase
      end
   end

   assign bus.Dado      = r_dado;
   assign bus.Hab       = r_hab;
   assign bus.Ocupado   = r_ocupado;
   assign bus.Concluido = r_concl;
   assign bus.Erro      = r_erro;
   assign bus.Indice    = 4'(r_idx);
endmodule

// File: tb/tb_transmissor_palavras.sv
// Directed bench for transmissor_palavras: N=4, TIMEOUT=15; inputs driven
// and outputs sampled on the falling edge.
module tb_transmissor_palavras;
   logic clk = 1'b0;
   logic rst;
   logic auto_en, fim_man, fim_auto;
   int   n_chk = 0;
   int   n_fail = 0;

   transmissor_palavras_if #(.N(4)) bus();

   transmissor_palavras #(.N(4), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Consumer that raises Fim for one cycle after its first Hab cycle.
   always @(posedge clk) begin
      if (rst) fim_auto <= 1'b0;
      else     fim_auto <= bus.Hab & ~fim_auto;
   end
   assign bus.Fim = auto_en ? fim_auto : fim_man;

   task automatic do_reset();
      rst = 1'b1; bus.Inicio = 1'b0; auto_en = 1'b0; fim_man = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start(input logic [15:0] p);
      bus.Palavras = p; bus.Inicio = 1'b1;
      @(negedge clk);
      bus.Inicio = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.Inicio = 1'b0; bus.Palavras = 16'h0; auto_en = 1'b0; fim_man = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b0) begin n_fail++; $display("FAIL rst_hab got %b exp 0", bus.Hab); end
      n_chk++; if (bus.Ocupado !== 1'b0) begin n_fail++; $display("FAIL rst_ocup got %b exp 0", bus.Ocupado); end
      n_chk++; if (bus.Concluido !== 1'b0) begin n_fail++; $display("FAIL rst_concl got %b exp 0", bus.Concluido); end
      n_chk++; if (bus.Erro !== 1'b0) begin n_fail++; $display("FAIL rst_erro got %b exp 0", bus.Erro); end
      n_chk++; if (bus.Dado !== 4'h0) begin n_fail++; $display("FAIL rst_dado got %h exp 0", bus.Dado); end
      n_chk++; if (bus.Indice !== 4'h0) begin n_fail++; $display("FAIL rst_idx got %h exp 0", bus.Indice); end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      logic [3:0] w [4];
      logic [3:0] e_idx, e_dado;
      logic       e_hab;
      int         pulses;
      w[0] = 4'h3; w[1] = 4'hC; w[2] = 4'h5; w[3] = 4'hA;
      pulses = 0;
      do_reset();
      auto_en = 1'b1;
      start(16'hA5C3);
      for (int c = 0; c <= 14; c++) begin
         if (c > 0) @(negedge clk);
         e_idx  = (c >= 12) ? 4'd3 : 4'(c / 3);
         e_dado = w[e_idx];
         e_hab  = (c < 12) && (c % 3 != 2);
         if (bus.Concluido === 1'b1) pulses++;
         n_chk++; if (bus.Hab !== e_hab) begin n_fail++; $display("FAIL nom_hab c=%0d got %b exp %b", c, bus.Hab, e_hab); end
         n_chk++; if (bus.Dado !== e_dado) begin n_fail++; $display("FAIL nom_dado c=%0d got %h exp %h", c, bus.Dado, e_dado); end
         n_chk++; if (bus.Indice !== e_idx) begin n_fail++; $display("FAIL nom_idx c=%0d got %0d exp %0d", c, bus.Indice, e_idx); end
         n_chk++; if (bus.Ocupado !== (c < 12)) begin n_fail++; $display("FAIL nom_ocup c=%0d got %b exp %b", c, bus.Ocupado, c < 12); end
         n_chk++; if (bus.Concluido !== (c == 12)) begin n_fail++; $display("FAIL nom_concl c=%0d got %b exp %b", c, bus.Concluido, c == 12); end
      end
      n_chk++; if (pulses !== 1) begin n_fail++; $display("FAIL nom_pulses got %0d exp 1", pulses); end
      n_chk++; if (bus.Erro !== 1'b0) begin n_fail++; $display("FAIL nom_erro got %b exp 0", bus.Erro); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      auto_en = 1'b1;
      start(16'hA5C3);
      repeat (6) @(negedge clk);
      n_chk++; if (bus.Indice !== 4'd2 || bus.Hab !== 1'b1) begin n_fail++; $display("FAIL mid_pre got idx=%0d hab=%b exp idx=2 hab=1", bus.Indice, bus.Hab); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if (bus.Hab !== 1'b0) begin n_fail++; $display("FAIL mid_hab got %b exp 0", bus.Hab); end
      n_chk++; if (bus.Ocupado !== 1'b0) begin n_fail++; $display("FAIL mid_ocup got %b exp 0", bus.Ocupado); end
      n_chk++; if (bus.Indice !== 4'd0) begin n_fail++; $display("FAIL mid_idx got %0d exp 0", bus.Indice); end
      n_chk++; if (bus.Dado !== 4'h0) begin n_fail++; $display("FAIL mid_dado got %h exp 0", bus.Dado); end
      n_chk++; if (bus.Erro !== 1'b0) begin n_fail++; $display("FAIL mid_erro got %b exp 0", bus.Erro); end
      start(16'hA5C3);
      n_chk++; if (bus.Dado !== 4'h3 || bus.Indice !== 4'd0 || bus.Hab !== 1'b1) begin n_fail++; $display("FAIL mid_restart got dado=%h idx=%0d hab=%b exp 3 0 1", bus.Dado, bus.Indice, bus.Hab); end
      repeat (12) @(negedge clk);
      n_chk++; if (bus.Concluido !== 1'b1 || bus.Indice !== 4'd3) begin n_fail++; $display("FAIL mid_done got concl=%b idx=%0d exp 1 3", bus.Concluido, bus.Indice); end
   endtask

   task automatic test_timeout_low();
      do_reset();
      start(16'hA5C3);
      for (int c = 0; c <= 15; c++) begin
         if (c > 0) @(negedge clk);
         n_chk++; if (bus.Hab !== (c < 15)) begin n_fail++; $display("FAIL tlo_hab c=%0d got %b exp %b", c, bus.Hab, c < 15); end
      end
      n_chk++; if (bus.Erro !== 1'b1) begin n_fail++; $display("FAIL tlo_erro got %b exp 1", bus.Erro); end
      n_chk++; if (bus.Ocupado !== 1'b0) begin n_fail++; $display("FAIL tlo_ocup got %b exp 0", bus.Ocupado); end
      repeat (3) @(negedge clk);
      n_chk++; if (bus.Erro !== 1'b1) begin n_fail++; $display("FAIL tlo_sticky got %b exp 1", bus.Erro); end
      start(16'hA5C3);
      n_chk++; if (bus.Erro !== 1'b0 || bus.Hab !== 1'b1) begin n_fail++; $display("FAIL tlo_clear got erro=%b hab=%b exp 0 1", bus.Erro, bus.Hab); end
   endtask

   task automatic test_stuck_high();
      do_reset();
      fim_man = 1'b1;
      @(negedge clk);
      start(16'hA5C3);
      n_chk++; if (bus.Hab !== 1'b1) begin n_fail++; $display("FAIL shi_c0 got hab=%b exp 1", bus.Hab); end
      @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b1) begin n_fail++; $display("FAIL shi_c1 got hab=%b exp 1", bus.Hab); end
      @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b0 || bus.Ocupado !== 1'b1) begin n_fail++; $display("FAIL shi_c2 got hab=%b ocup=%b exp 0 1", bus.Hab, bus.Ocupado); end
      repeat (14) @(negedge clk);
      n_chk++; if (bus.Erro !== 1'b0 || bus.Ocupado !== 1'b1) begin n_fail++; $display("FAIL shi_c16 got erro=%b ocup=%b exp 0 1", bus.Erro, bus.Ocupado); end
      @(negedge clk);
      n_chk++; if (bus.Erro !== 1'b1 || bus.Ocupado !== 1'b0 || bus.Hab !== 1'b0) begin n_fail++; $display("FAIL shi_c17 got erro=%b ocup=%b hab=%b exp 1 0 0", bus.Erro, bus.Ocupado, bus.Hab); end
   endtask

   task automatic test_ignore_inicio();
      do_reset();
      auto_en = 1'b1;
      start(16'hA5C3);
      repeat (3) @(negedge clk);
      bus.Palavras = 16'h1234; bus.Inicio = 1'b1;
      n_chk++; if (bus.Dado !== 4'hC) begin n_fail++; $display("FAIL ign_c3 got %h exp c", bus.Dado); end
      @(negedge clk);
      bus.Inicio = 1'b0;
      n_chk++; if (bus.Indice !== 4'd1 || bus.Dado !== 4'hC) begin n_fail++; $display("FAIL ign_c4 got idx=%0d dado=%h exp 1 c", bus.Indice, bus.Dado); end
      repeat (2) @(negedge clk);
      n_chk++; if (bus.Dado !== 4'h5) begin n_fail++; $display("FAIL ign_c6 got %h exp 5", bus.Dado); end
      repeat (3) @(negedge clk);
      n_chk++; if (bus.Dado !== 4'hA) begin n_fail++; $display("FAIL ign_c9 got %h exp a", bus.Dado); end
      repeat (3) @(negedge clk);
      n_chk++; if (bus.Concluido !== 1'b1) begin n_fail++; $display("FAIL ign_c12 got %b exp 1", bus.Concluido); end
   endtask

   task automatic test_slow();
      do_reset();
      start(16'hA5C3);
      repeat (9) @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b1 || bus.Erro !== 1'b0) begin n_fail++; $display("FAIL slow_c9 got hab=%b erro=%b exp 1 0", bus.Hab, bus.Erro); end
      fim_man = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b0 || bus.Ocupado !== 1'b1) begin n_fail++; $display("FAIL slow_c10 got hab=%b ocup=%b exp 0 1", bus.Hab, bus.Ocupado); end
      fim_man = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b1 || bus.Indice !== 4'd1 || bus.Dado !== 4'hC) begin n_fail++; $display("FAIL slow_c11 got hab=%b idx=%0d dado=%h exp 1 1 c", bus.Hab, bus.Indice, bus.Dado); end
      repeat (14) @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b1 || bus.Erro !== 1'b0) begin n_fail++; $display("FAIL slow_c25 got hab=%b erro=%b exp 1 0", bus.Hab, bus.Erro); end
      fim_man = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.Hab !== 1'b0 || bus.Erro !== 1'b0 || bus.Ocupado !== 1'b1) begin n_fail++; $display("FAIL slow_tc got hab=%b erro=%b ocup=%b exp 0 0 1", bus.Hab, bus.Erro, bus.Ocupado); end
      fim_man = 1'b0;
      @(negedge clk);
      n_chk++; if (bus.Indice !== 4'd2 || bus.Hab !== 1'b1 || bus.Erro !== 1'b0) begin n_fail++; $display("FAIL slow_c27 got idx=%0d hab=%b erro=%b exp 2 1 0", bus.Indice, bus.Hab, bus.Erro); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_reset_mid();
      test_timeout_low();
      test_stuck_high();
      test_ignore_inicio();
      test_slow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
